lcd_page_sched: RTL and testbench
=================================

# lcd_page_sched

Page scheduler and frame store for the 4-bit character-LCD display controller (`lcd_display4`). It holds four display pages; each page is two 16-digit lines with a per-digit visibility mask. It rotates the enabled pages on a fixed dwell time and drives the controller's `f1`/`f2`/`m1`/`m2` frame inputs. It sits between firmware/status logic (write port, page control) and the display controller, in the same slow clock domain as the controller.

## Interface

Parameters:
- `DWELL`, default 24'd6250000: cycles each page stays shown (about 2 s at a 3.125 MHz display clock); must be ≥ 2.
- `DW`, default 24: width of the dwell counter; DWELL-1 must fit in DW bits.

Ports:
- `clk` in 1: display clock, same net as the controller's `clk`.
- `rst` in 1: reset, synchronous, active-high.
- `wr_en` in 1: write one page line this cycle.
- `wr_page` in 2: target page.
- `wr_line` in 1: 0 = line 1 (`f1`/`m1`), 1 = line 2 (`f2`/`m2`).
- `wr_data` in 64: 16 hex digits; the digit 0 nibble is [63:60].
- `wr_mask` in 16: per-digit visibility, 1 = shown; bit 15 is digit 0.
- `page_en` in 4: pages that take part in rotation.
- `hold` in 1: freeze the dwell countdown.
- `sel_req` in 1: jump immediately to `sel_page`.
- `sel_page` in 2: jump target.
- `f1`, `f2` out 64: digit lines to the controller.
- `m1`, `m2` out 16: masks to the controller.
- `cur_page` out 2: page being shown.
- `page_stb` out 1: one-cycle pulse when a new page first appears on `f*`/`m*`.
- `idle` out 1: no page is enabled; the display is blanked.

## Operation

Page buffer:
- 4 pages × 2 lines × (64 + 16) bits, all cleared to 0 by `rst`.
- `wr_en` writes `wr_data` and `wr_mask` into `{wr_page, wr_line}` at the clock edge. Writes ignore `page_en` and the scheduler state.
- `wr_en` is ignored while `rst` is high.

FSM states: IDLE, SHOW, NEXT.
- **Reset:** state IDLE, `cur_page`=0, counter=0. Outputs: `f1`/`f2`/`m1`/`m2`=0, `page_stb`=0, `idle`=1.
- **IDLE:**
  - Counter held at 0.
  - `m1`/`m2` forced to 0; `f1`/`f2` keep their last value.
  - If `page_en`≠0: `cur_page` ← first enabled page searching cur, cur+1, cur+2, cur+3 (mod 4); go to SHOW; a strobe follows.
- **SHOW:** the following rules are applied in priority order.
  1. `page_en`==0: go to IDLE.
  2. `sel_req` with `page_en[sel_page]`=1: `cur_page` ← `sel_page`, counter ← 0, stay in SHOW. A strobe follows only if the page changed.
  3. `sel_req` targeting a disabled page: ignored.
  4. `page_en[cur_page]`=0: go to NEXT; counter ← 0.
  5. `hold`=1: counter holds.
  6. Counter==DWELL-1: go to NEXT; counter ← 0.
  7. Otherwise: counter increments.
- **NEXT:** a single cycle.
  - `cur_page` ← first enabled page searching cur+1, cur+2, cur+3, cur (mod 4); go to SHOW.
  - If `page_en`==0 at this point, go to IDLE instead.
  - A strobe follows only if `cur_page` changed. With a single enabled page, it re-dwells on that page with no strobe.
- `sel_req` is ignored in IDLE and in NEXT. `hold` never blocks `sel_req`, the page_en drop rule (rule 4), or IDLE entry.
- `idle` = (state==IDLE), registered.

## Timing

- `f1`/`f2`/`m1`/`m2` are registered from `buffer[cur_page]`.
  - They show the new page one cycle after `cur_page` updates.
  - They reflect a write to the shown page one cycle after the write edge.
- A write and a page change on the same edge: the new page is shown with the written data.
- `page_stb` is asserted in the same cycle `f*`/`m*` first present the new page, i.e. 1 cycle after `cur_page` changes.
- Free-running rotation period is DWELL+1 cycles per page (DWELL SHOW cycles + 1 NEXT cycle), extended one-for-one by cycles with `hold` asserted.
- `sel_req` to page P at edge k: `cur_page`=P after edge k; outputs and `page_stb` update after edge k+1; the dwell restarts at full length.
- IDLE entry: `m1`/`m2`=0 and `idle`=1 one cycle after the state change.
- `rst` mid-operation: all state, the buffer and the outputs return to their reset values on that edge.

## Test plan

All scenarios use DWELL=4.

1. **Reset:** assert `rst` 2 cycles with random `wr_en` → `f*`/`m*`=0, `cur_page`=0, `idle`=1, `page_stb`=0; the buffer reads back all zero.
2. **Write then enable:**
   - Write page 0, line 0, 64'h123456f890abcde7 / 16'h575F; then set `page_en`=4'b0001.
   - Expect one `page_stb`; `f1`=64'h123456f890abcde7, `m1`=16'h575F, `m2`=0, `idle`=0.
   - Rewrite line 0 to 64'h7645321dcbaef987 → `f1` updates 2 cycles after the `wr_en` cycle (1 cycle after the write edge), with no strobe.
3. **Rotation:** `page_en`=4'b1011 from page 0 → `cur_page` sequence 0,1,3,0,1, with `page_stb` spaced exactly 5 cycles apart.
4. **Hold:** assert `hold` 10 cycles mid-dwell → no change and no strobe; after release, the page advances after the remaining count (the total interval grows by exactly 10).
5. **Select:**
   - `sel_req`/`sel_page`=3 while on page 1 at count 2 → `cur_page`=3 next cycle, strobe 1 cycle later, full 4-cycle dwell.
   - `sel_page`=2 with `page_en[2]`=0 → no effect.
6. **Disable:**
   - Clear `page_en` for the current page mid-dwell → NEXT on the next cycle, advancing to the next enabled page.
   - Set `page_en`=0 → IDLE, `m1`/`m2`=0, `idle`=1.
   - Re-enable page 2 → SHOW page 2 with a strobe.

Source files
------------

// File: rtl/lcd_page_sched.sv
// Four-page frame store with timed page rotation feeding the lcd_display4 frame inputs.
// Pages hold two 16-digit lines plus per-digit masks; the scheduler cycles enabled pages.
module lcd_page_sched #(
    parameter int unsigned    DW    = 24,
    parameter logic [DW-1:0]  DWELL = DW'(6250000)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_page,
    input  logic        wr_line,
    input  logic [63:0] wr_data,
    input  logic [15:0] wr_mask,
    input  logic [3:0]  page_en,
    input  logic        hold,
    input  logic        sel_req,
    input  logic [1:0]  sel_page,
    output logic [63:0] f1,
    output logic [63:0] f2,
    output logic [15:0] m1,
    output logic [15:0] m2,
    output logic [1:0]  cur_page,
    output logic        page_stb,
    output logic        idle
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned MASK_W = 16;
    localparam int unsigned NE     = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_NEXT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        cur_q, cur_d;
    logic [DW-1:0]     cnt_q, cnt_d;
    logic              pend_q, pend_d;

    logic [DATA_W-1:0] data_q [NE];
    logic [DATA_W-1:0] data_d [NE];
    logic [MASK_W-1:0] mask_q [NE];
    logic [MASK_W-1:0] mask_d [NE];

    logic [DATA_W-1:0] f1_q, f1_d, f2_q, f2_d;
    logic [MASK_W-1:0] m1_q, m1_d, m2_q, m2_d;
    logic              page_stb_q, page_stb_d;
    logic              idle_q, idle_d;
    logic [1:0]        nxt_page;

    // First enabled page scanning start, start+1, start+2, start+3 (mod 4).
    function automatic logic [1:0] first_en(input logic [3:0] en, input logic [1:0] start);
        logic [1:0] pick;
        pick = start;
        for (int i = 3; i >= 0; i--) begin
            if (en[start + 2'(i)]) pick = start + 2'(i);
        end
        return pick;
    endfunction

    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        if (wr_en) begin
            data_d[{wr_page, wr_line}] = wr_data;
            mask_d[{wr_page, wr_line}] = wr_mask;
        end
    end

    // Scheduler next-state; pend_d marks that a new page becomes visible next cycle.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        cnt_d    = cnt_q;
        pend_d   = 1'b0;
        nxt_page = first_en(page_en, cur_q + 2'd1);
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (page_en != 4'd0) begin
                    cur_d   = first_en(page_en, cur_q);
                    state_d = S_SHOW;
                    pend_d  = 1'b1;
                end
            end
            S_SHOW: begin
                if (page_en == 4'd0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (sel_req && page_en[sel_page]) begin
                    cur_d  = sel_page;
                    cnt_d  = '0;
                    pend_d = (sel_page != cur_q);
                end else if (!page_en[cur_q]) begin
                    state_d = S_NEXT;
                    cnt_d   = '0;
                end else if (!hold) begin
                    if (cnt_q == DWELL - DW'(1)) begin
                        state_d = S_NEXT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DW'(1);
                    end
                end
            end
            S_NEXT: begin
                cnt_d = '0;
                if (page_en == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cur_d   = nxt_page;
                    pend_d  = (nxt_page != cur_q);
                    state_d = S_SHOW;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output stage: frames follow the shown page; IDLE blanks masks but keeps digits.
    always_comb begin
        f1_d       = f1_q;
        f2_d       = f2_q;
        m1_d       = '0;
        m2_d       = '0;
        idle_d     = (state_q == S_IDLE);
        page_stb_d = pend_q;
        if (state_q != S_IDLE) begin
            f1_d = data_q[{cur_q, 1'b0}];
            f2_d = data_q[{cur_q, 1'b1}];
            m1_d = mask_q[{cur_q, 1'b0}];
            m2_d = mask_q[{cur_q, 1'b1}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NE); i++) begin
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
            state_q    <= S_IDLE;
            cur_q      <= 2'd0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            f1_q       <= '0;
            f2_q       <= '0;
            m1_q       <= '0;
            m2_q       <= '0;
            page_stb_q <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            state_q    <= state_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            f1_q       <= f1_d;
            f2_q       <= f2_d;
            m1_q       <= m1_d;
            m2_q       <= m2_d;
            page_stb_q <= page_stb_d;
            idle_q     <= idle_d;
        end
    end

    assign f1       = f1_q;
    assign f2       = f2_q;
    assign m1       = m1_q;
    assign m2       = m2_q;
    assign cur_page = cur_q;
    assign page_stb = page_stb_q;
    assign idle     = idle_q;

endmodule

// File: tb/tb_lcd_page_sched.sv
// Directed bench for lcd_page_sched with DWELL=4: vector table for write/rotation,
// hand sequences for hold, select, disable, idle and mid-run reset.
module tb_lcd_page_sched;

    localparam logic [63:0] D0  = 64'h123456f890abcde7;
    localparam logic [15:0] M0  = 16'h575F;
    localparam logic [63:0] D0B = 64'h7645321dcbaef987;
    localparam logic [63:0] D1  = 64'hA1A2A3A4A5A6A7A8;
    localparam logic [15:0] M1  = 16'hFFFF;
    localparam logic [63:0] D2  = 64'hCAFEF00D12345678;
    localparam logic [15:0] M2  = 16'hF0F0;
    localparam logic [63:0] D3  = 64'h0F0E0D0C0B0A0908;
    localparam logic [15:0] M3  = 16'h00FF;
    localparam logic [63:0] Z64 = 64'd0;
    localparam logic [15:0] Z16 = 16'd0;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_page;
    logic        wr_line;
    logic [63:0] wr_data;
    logic [15:0] wr_mask;
    logic [3:0]  page_en;
    logic        hold;
    logic        sel_req;
    logic [1:0]  sel_page;
    logic [63:0] f1, f2;
    logic [15:0] m1, m2;
    logic [1:0]  cur_page;
    logic        page_stb;
    logic        idle;

    int errors;
    int checks;

    typedef struct {
        logic        rst;
        logic        wr_en;
        logic [1:0]  wr_page;
        logic        wr_line;
        logic [63:0] wr_data;
        logic [15:0] wr_mask;
        logic [3:0]  page_en;
        logic [1:0]  e_cur;
        logic        e_stb;
        logic        e_idle;
        logic [63:0] e_f1;
        logic [15:0] e_m1;
        logic [63:0] e_f2;
        logic [15:0] e_m2;
    } vec_t;

    vec_t vecs [22];

    lcd_page_sched #(.DW(24), .DWELL(24'd4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_page  (wr_page),
        .wr_line  (wr_line),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask),
        .page_en  (page_en),
        .hold     (hold),
        .sel_req  (sel_req),
        .sel_page (sel_page),
        .f1       (f1),
        .f2       (f2),
        .m1       (m1),
        .m2       (m2),
        .cur_page (cur_page),
        .page_stb (page_stb),
        .idle     (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mkv(input logic r, input logic we, input logic [1:0] wp, input logic wl,
                                 input logic [63:0] wd, input logic [15:0] wm, input logic [3:0] pe,
                                 input logic [1:0] ec, input logic es, input logic ei,
                                 input logic [63:0] ef1, input logic [15:0] em1,
                                 input logic [63:0] ef2, input logic [15:0] em2);
        vec_t v;
        v.rst = r;   v.wr_en = we;  v.wr_page = wp; v.wr_line = wl;
        v.wr_data = wd; v.wr_mask = wm; v.page_en = pe;
        v.e_cur = ec; v.e_stb = es; v.e_idle = ei;
        v.e_f1 = ef1; v.e_m1 = em1; v.e_f2 = ef2; v.e_m2 = em2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] ec, input logic es, input logic ei,
                           input logic [63:0] ef1, input logic [15:0] em1,
                           input logic [63:0] ef2, input logic [15:0] em2);
        chk({tag, ".cur_page"}, 64'(cur_page), 64'(ec));
        chk({tag, ".page_stb"}, 64'(page_stb), 64'(es));
        chk({tag, ".idle"},     64'(idle),     64'(ei));
        chk({tag, ".f1"},       f1,            ef1);
        chk({tag, ".m1"},       64'(m1),       64'(em1));
        chk({tag, ".f2"},       f2,            ef2);
        chk({tag, ".m2"},       64'(m2),       64'(em2));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_page  = 2'd0;
        wr_line  = 1'b0;
        wr_data  = '0;
        wr_mask  = '0;
        page_en  = 4'd0;
        hold     = 1'b0;
        sel_req  = 1'b0;
        sel_page = 2'd0;

        // Reset with writes/enables that must be ignored, then load pages 0,1,3 and rotate.
        vecs[0]  = mkv(1'b1, 1'b1, 2'd0, 1'b0, 64'hDEAD, 16'hFFFF, 4'hF,    2'd0, 1'b0, 1'b1, Z64, Z16, Z64, Z16);
        vecs[1]  = mkv(1'b1, 1'b1, 2'd1, 1'b1, 64'hBEEF, 16'h1234, 4'h0,    2'd0, 1'b0, 1'b1, Z64, Z16, Z64, Z16);
        vecs[2]  = mkv(1'b0, 1'b1, 2'd0, 1'b0, D0,  M0,  4'h0,              2'd0, 1'b0, 1'b1, Z64, Z16, Z64, Z16);
        vecs[3]  = mkv(1'b0, 1'b1, 2'd1, 1'b1, D1,  M1,  4'h0,              2'd0, 1'b0, 1'b1, Z64, Z16, Z64, Z16);
        vecs[4]  = mkv(1'b0, 1'b1, 2'd3, 1'b0, D3,  M3,  4'h0,              2'd0, 1'b0, 1'b1, Z64, Z16, Z64, Z16);
        vecs[5]  = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b0001,           2'd0, 1'b0, 1'b1, Z64, Z16, Z64, Z16);
        vecs[6]  = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b0001,           2'd0, 1'b1, 1'b0, D0,  M0,  Z64, Z16);
        vecs[7]  = mkv(1'b0, 1'b1, 2'd0, 1'b0, D0B, M0,  4'b0001,           2'd0, 1'b0, 1'b0, D0,  M0,  Z64, Z16);
        vecs[8]  = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b0001,           2'd0, 1'b0, 1'b0, D0B, M0,  Z64, Z16);
        vecs[9]  = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b1011,           2'd0, 1'b0, 1'b0, D0B, M0,  Z64, Z16);
        vecs[10] = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b1011,           2'd1, 1'b0, 1'b0, D0B, M0,  Z64, Z16);
        vecs[11] = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b1011,           2'd1, 1'b1, 1'b0, Z64, Z16, D1,  M1);
        vecs[12] = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b1011,           2'd1, 1'b0, 1'b0, Z64, Z16, D1,  M1);
        vecs[13] = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b1011,           2'd1, 1'b0, 1'b0, Z64, Z16, D1,  M1);
        vecs[14] = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b1011,           2'd1, 1'b0, 1'b0, Z64, Z16, D1,  M1);
        vecs[15] = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b1011,           2'd3, 1'b0, 1'b0, Z64, Z16, D1,  M1);
        vecs[16] = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b1011,           2'd3, 1'b1, 1'b0, D3,  M3,  Z64, Z16);
        vecs[17] = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b1011,           2'd3, 1'b0, 1'b0, D3,  M3,  Z64, Z16);
        vecs[18] = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b1011,           2'd3, 1'b0, 1'b0, D3,  M3,  Z64, Z16);
        vecs[19] = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b1011,           2'd3, 1'b0, 1'b0, D3,  M3,  Z64, Z16);
        vecs[20] = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b1011,           2'd0, 1'b0, 1'b0, D3,  M3,  Z64, Z16);
        vecs[21] = mkv(1'b0, 1'b0, 2'd0, 1'b0, Z64, Z16, 4'b1011,           2'd0, 1'b1, 1'b0, D0B, M0,  Z64, Z16);

        for (int i = 0; i < 22; i++) begin
            rst     = vecs[i].rst;
            wr_en   = vecs[i].wr_en;
            wr_page = vecs[i].wr_page;
            wr_line = vecs[i].wr_line;
            wr_data = vecs[i].wr_data;
            wr_mask = vecs[i].wr_mask;
            page_en = vecs[i].page_en;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_cur, vecs[i].e_stb, vecs[i].e_idle,
                    vecs[i].e_f1, vecs[i].e_m1, vecs[i].e_f2, vecs[i].e_m2);
        end
        wr_en = 1'b0;

        // Hold 10 cycles mid-dwell on page 0: no movement, then the 5-edge remainder.
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("hold%0d.cur_page", i), 64'(cur_page), 64'd0);
            chk($sformatf("hold%0d.page_stb", i), 64'(page_stb), 64'd0);
        end
        hold = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (page_stb) break;
        end
        chk("hold_gap_after_release", 64'(n), 64'd5);
        chk("hold_total_interval", 64'(n + 10), 64'd15);
        chk("hold_next.cur_page", 64'(cur_page), 64'd1);
        chk("hold_next.f2", f2, D1);

        // Select page 3 at count 2 on page 1.
        tick();
        chk("pre_sel.cur_page", 64'(cur_page), 64'd1);
        sel_req  = 1'b1;
        sel_page = 2'd3;
        tick();
        sel_req  = 1'b0;
        chk("sel3.cur_page", 64'(cur_page), 64'd3);
        chk("sel3.page_stb", 64'(page_stb), 64'd0);
        chk("sel3.f2_old", f2, D1);
        tick();
        chk("sel3_stb.page_stb", 64'(page_stb), 64'd1);
        chk("sel3_stb.f1", f1, D3);
        chk("sel3_stb.m1", 64'(m1), 64'(M3));
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (cur_page != 2'd3) break;
        end
        chk("sel3_dwell_edges", 64'(n), 64'd5);
        chk("sel3_after.cur_page", 64'(cur_page), 64'd0);
        tick();
        chk("sel3_after.page_stb", 64'(page_stb), 64'd1);

        // Select of a disabled page is ignored.
        sel_req  = 1'b1;
        sel_page = 2'd2;
        tick();
        sel_req  = 1'b0;
        chk("sel2_dis.cur_page", 64'(cur_page), 64'd0);
        chk("sel2_dis.page_stb", 64'(page_stb), 64'd0);
        tick();
        chk("sel2_dis2.cur_page", 64'(cur_page), 64'd0);
        chk("sel2_dis2.page_stb", 64'(page_stb), 64'd0);

        // Select wins over the dwell expiry on the same edge.
        sel_req  = 1'b1;
        sel_page = 2'd1;
        tick();
        sel_req  = 1'b0;
        chk("sel1.cur_page", 64'(cur_page), 64'd1);
        tick();
        chk("sel1.page_stb", 64'(page_stb), 64'd1);
        chk("sel1.f2", f2, D1);

        // Drop the shown page mid-dwell: NEXT then page 3.
        page_en = 4'b1001;
        tick();
        chk("drop.cur_page", 64'(cur_page), 64'd1);
        chk("drop.page_stb", 64'(page_stb), 64'd0);
        tick();
        chk("drop_next.cur_page", 64'(cur_page), 64'd3);
        chk("drop_next.page_stb", 64'(page_stb), 64'd0);
        tick();
        chk("drop_show.page_stb", 64'(page_stb), 64'd1);
        chk("drop_show.f1", f1, D3);
        chk("drop_show.m1", 64'(m1), 64'(M3));

        // All pages disabled: IDLE blanks masks, keeps digits; write page 2 meanwhile.
        page_en = 4'd0;
        tick();
        chk("idle_entry.idle", 64'(idle), 64'd0);
        chk("idle_entry.m1", 64'(m1), 64'(M3));
        wr_en   = 1'b1;
        wr_page = 2'd2;
        wr_line = 1'b0;
        wr_data = D2;
        wr_mask = M2;
        tick();
        wr_en   = 1'b0;
        chk("idle.idle", 64'(idle), 64'd1);
        chk("idle.m1", 64'(m1), 64'd0);
        chk("idle.m2", 64'(m2), 64'd0);
        chk("idle.f1_kept", f1, D3);
        chk("idle.cur_page", 64'(cur_page), 64'd3);

        // Re-enable page 2 only.
        page_en = 4'b0100;
        tick();
        chk("reen.cur_page", 64'(cur_page), 64'd2);
        chk("reen.page_stb", 64'(page_stb), 64'd0);
        chk("reen.idle", 64'(idle), 64'd1);
        tick();
        chk_all("reen_show", 2'd2, 1'b1, 1'b0, D2, M2, Z64, Z16);

        // Mid-run reset clears state, outputs and the buffer.
        rst = 1'b1;
        tick();
        chk_all("midrst", 2'd0, 1'b0, 1'b1, Z64, Z16, Z64, Z16);
        rst = 1'b0;
        tick();
        chk("postrst.cur_page", 64'(cur_page), 64'd2);
        tick();
        chk_all("postrst_show", 2'd2, 1'b1, 1'b0, Z64, Z16, Z64, Z16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
